// File: rtl/state_dump_unit.sv
// state_dump_unit: freezes the CPU, then streams the register bank and data RAM over valid/ready.
// Optional macro DUMP_CHECKSUM_EN appends an XOR checksum word after the last RAM word.
module state_dump_unit #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned REG_FIRST    = 1,
  parameter int unsigned REG_LAST     = 31,
  parameter int unsigned RAM_ADDR_W   = 8,
  parameter int unsigned RAM_WORDS    = 5,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  cpu_enable,
  output logic                  busy,
  output logic                  done,
  output logic [REG_ADDR_W-1:0] reg_rd_addr,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  output logic [RAM_ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            out_tag,
  output logic [7:0]            out_index
);

  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int unsigned TAG_W   = 2;
  localparam int unsigned IDX_W   = 8;
  localparam logic [TAG_W-1:0] TAG_REG = 2'b00;
  localparam logic [TAG_W-1:0] TAG_RAM = 2'b01;
`ifdef DUMP_CHECKSUM_EN
  localparam logic [TAG_W-1:0] TAG_CSUM = 2'b10;
`endif

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_REG,
    ST_REG_OUT,
    ST_RAM_ADDR,
    ST_RAM_WAIT,
    ST_RAM_OUT,
`ifdef DUMP_CHECKSUM_EN
    ST_CSUM,
    ST_CSUM_OUT,
`endif
    ST_FINISH
  } state_t;

  state_t state, next_state;

  logic [DRAIN_W-1:0] drain_cnt;
  logic handshake, reg_last, ram_last, drain_done;
  logic clear_run, drain_step, load_reg, step_reg, enter_ram, load_ram, step_ram;
`ifdef DUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum;
  logic load_csum, word_accepted;
`endif

  assign handshake  = out_valid & out_ready;
  assign reg_last   = (reg_rd_addr == REG_ADDR_W'(REG_LAST));
  assign ram_last   = (ram_rd_addr == RAM_ADDR_W'(RAM_WORDS - 1));
  assign drain_done = (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1));

  // State register
  always_ff @(posedge clock) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:     if (start) next_state = ST_DRAIN;
      ST_DRAIN:    if (drain_done) next_state = ST_REG;
      ST_REG:      next_state = ST_REG_OUT;
      ST_REG_OUT:  if (handshake) next_state = reg_last ? ST_RAM_ADDR : ST_REG;
      ST_RAM_ADDR: next_state = ST_RAM_WAIT;
      ST_RAM_WAIT: next_state = ST_RAM_OUT;
`ifdef DUMP_CHECKSUM_EN
      ST_RAM_OUT:  if (handshake) next_state = ram_last ? ST_CSUM : ST_RAM_ADDR;
      ST_CSUM:     next_state = ST_CSUM_OUT;
      ST_CSUM_OUT: if (handshake) next_state = ST_FINISH;
`else
      ST_RAM_OUT:  if (handshake) next_state = ram_last ? ST_FINISH : ST_RAM_ADDR;
`endif
      ST_FINISH:   next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  // Datapath strobes decoded from the current state
  always_comb begin
    clear_run  = 1'b0;
    drain_step = 1'b0;
    load_reg   = 1'b0;
    step_reg   = 1'b0;
    enter_ram  = 1'b0;
    load_ram   = 1'b0;
    step_ram   = 1'b0;
`ifdef DUMP_CHECKSUM_EN
    load_csum     = 1'b0;
    word_accepted = 1'b0;
`endif
    case (state)
      ST_IDLE:     clear_run  = start;
      ST_DRAIN:    drain_step = 1'b1;
      ST_REG:      load_reg   = 1'b1;
      ST_REG_OUT: begin
        step_reg  = handshake & ~reg_last;
        enter_ram = handshake & reg_last;
`ifdef DUMP_CHECKSUM_EN
        word_accepted = handshake;
`endif
      end
      ST_RAM_WAIT: load_ram = 1'b1;
      ST_RAM_OUT: begin
        step_ram = handshake & ~ram_last;
`ifdef DUMP_CHECKSUM_EN
        word_accepted = handshake;
`endif
      end
`ifdef DUMP_CHECKSUM_EN
      ST_CSUM:     load_csum = 1'b1;
`endif
      default: ;
    endcase
  end

  // Registered outputs, read addresses and counters
  always_ff @(posedge clock) begin
    if (!reset) begin
      cpu_enable  <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_tag     <= '0;
      out_index   <= '0;
      reg_rd_addr <= '0;
      ram_rd_addr <= '0;
      drain_cnt   <= '0;
`ifdef DUMP_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      cpu_enable <= (next_state == ST_IDLE);
      busy       <= (next_state != ST_IDLE);
      done       <= (next_state == ST_FINISH);

      if (clear_run)       drain_cnt <= '0;
      else if (drain_step) drain_cnt <= drain_cnt + DRAIN_W'(1);

      if (drain_step)    reg_rd_addr <= REG_ADDR_W'(REG_FIRST);
      else if (step_reg) reg_rd_addr <= reg_rd_addr + REG_ADDR_W'(1);

      if (enter_ram)     ram_rd_addr <= '0;
      else if (step_ram) ram_rd_addr <= ram_rd_addr + RAM_ADDR_W'(1);

      if (load_reg) begin
        out_data  <= reg_rd_data;
        out_tag   <= TAG_REG;
        out_index <= IDX_W'(reg_rd_addr);
      end else if (load_ram) begin
        out_data  <= ram_rd_data;
        out_tag   <= TAG_RAM;
        out_index <= IDX_W'(ram_rd_addr);
      end
`ifdef DUMP_CHECKSUM_EN
      else if (load_csum) begin
        out_data  <= csum;
        out_tag   <= TAG_CSUM;
        out_index <= '0;
      end

      if (clear_run)          csum <= '0;
      else if (word_accepted) csum <= csum ^ out_data;

      if (load_reg | load_ram | load_csum) out_valid <= 1'b1;
      else if (handshake)                  out_valid <= 1'b0;
`else
      if (load_reg | load_ram) out_valid <= 1'b1;
      else if (handshake)      out_valid <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_state_dump_unit.sv
// tb_state_dump_unit: directed checks of the dump stream, stalls, ignored restart and mid-dump reset.
// Build with DUMP_CHECKSUM_EN to also check the trailing checksum word.
module tb_state_dump_unit;

  localparam int unsigned DRAIN = 4;
`ifdef DUMP_CHECKSUM_EN
  localparam int N_WORDS = 37;
`else
  localparam int N_WORDS = 36;
`endif

  logic        clock, reset, start, out_ready;
  logic        cpu_enable, busy, done, out_valid;
  logic [4:0]  reg_rd_addr;
  logic [7:0]  ram_rd_addr, out_index;
  logic [31:0] reg_rd_data, ram_rd_data, out_data, ram_q;
  logic [1:0]  out_tag;

  logic [31:0] regs [32];
  logic [31:0] ram  [256];
  logic [41:0] q_words [$];
  int          n_checks, n_fail, first_valid;

  state_dump_unit #(
    .DATA_WIDTH(32), .REG_ADDR_W(5), .REG_FIRST(1), .REG_LAST(31),
    .RAM_ADDR_W(8), .RAM_WORDS(5), .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .cpu_enable(cpu_enable), .busy(busy), .done(done),
    .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_index(out_index)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register bank read is combinational, RAM read has one cycle of latency
  assign reg_rd_data = regs[reg_rd_addr];
  always @(posedge clock) ram_q <= ram[ram_rd_addr];
  assign ram_rd_data = ram_q;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] exp_data(input int k, input bit regs_zero);
    if (k < 31) return regs_zero ? 32'h0 : 32'((k + 1) * 32'h11111111);
    return 32'hA0 + 32'(k - 31);
  endfunction

  // Expected {tag, index, data} of the k-th streamed word
  function automatic logic [41:0] exp_word(input int k, input bit regs_zero);
    logic [31:0] x;
    if (k < 31) return {2'b00, 8'(k + 1), exp_data(k, regs_zero)};
    if (k < 36) return {2'b01, 8'(k - 31), exp_data(k, regs_zero)};
    x = '0;
    for (int j = 0; j < 36; j++) x ^= exp_data(j, regs_zero);
    return {2'b10, 8'h00, x};
  endfunction

  task automatic verify_seq(input string name, input bit regs_zero);
    check_eq({name, "_count"}, 64'(q_words.size()), 64'(N_WORDS));
    for (int k = 0; k < q_words.size() && k < N_WORDS; k++)
      check_eq($sformatf("%s_w%0d", name, k), 64'(q_words[k]), 64'(exp_word(k, regs_zero)));
  endtask

  // mode 0: ready always high, mode 1: random ready. abort_at > 0 returns once that many words were taken.
  task automatic run_dump(input int mode, input bit restart, input int abort_at);
    int done_cnt, viol, late_done;
    bit stall, finished, re_sent;
    logic [41:0] prev;
    q_words.delete();
    first_valid = 0; done_cnt = 0; viol = 0; late_done = 0;
    stall = 0; finished = 0; re_sent = 0; prev = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("busy_after_start", {62'd0, busy, cpu_enable}, 64'b10);
    for (int cyc = 1; cyc < 3000; cyc++) begin
      start = 1'b0;
      if (finished) begin
        check_eq("idle_after_done", {62'd0, busy, cpu_enable}, 64'b01);
        break;
      end
      if (out_valid && first_valid == 0) first_valid = cyc;
      if (done) begin
        done_cnt++;
        finished = 1;
      end
      if (busy && cpu_enable) viol++;
      if (stall)
        check_eq("stall_hold", {21'd0, out_valid, out_tag, out_index, out_data}, {21'd0, 1'b1, prev});
      out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (out_valid && out_ready) q_words.push_back({out_tag, out_index, out_data});
      stall = out_valid && !out_ready;
      prev  = {out_tag, out_index, out_data};
      if (restart && !re_sent && q_words.size() == 10) begin
        start   = 1'b1;
        re_sent = 1;
      end
      if (abort_at > 0 && q_words.size() == abort_at) return;
      tick();
    end
    out_ready = 1'b1;
    if (!finished) check_eq("dump_timeout", 64'd0, 64'd1);
    check_eq("done_once", 64'(done_cnt), 64'd1);
    check_eq("cpu_held_off", 64'(viol), 64'd0);
    repeat (3) begin
      tick();
      if (done || busy) late_done++;
    end
    check_eq("quiet_after_done", 64'(late_done), 64'd0);
  endtask

  initial begin
    int stray;
    n_checks = 0; n_fail = 0;
    for (int i = 0; i < 32; i++) regs[i] = 32'(i * 32'h11111111);
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    for (int i = 0; i < 5; i++) ram[i] = 32'hA0 + 32'(i);

    // Reset held with start asserted
    reset = 1'b0; start = 1'b1; out_ready = 1'b1;
    repeat (3) tick();
    check_eq("reset_ctrl", {60'd0, cpu_enable, busy, done, out_valid}, 64'b1000);
    check_eq("reset_addr", {51'd0, reg_rd_addr, ram_rd_addr}, 64'd0);
    check_eq("reset_out", {22'd0, out_tag, out_index, out_data}, 64'd0);
    reset = 1'b1; start = 1'b0;
    repeat (3) tick();
    check_eq("no_dump_after_reset", {62'd0, busy, cpu_enable}, 64'b01);

    run_dump(0, 0, 0);
    check_eq("first_valid_latency", 64'(first_valid), 64'(DRAIN + 2));
    verify_seq("seq_ready", 0);

    run_dump(1, 0, 0);
    verify_seq("seq_stall", 0);

    run_dump(0, 1, 0);
    verify_seq("seq_restart", 0);

    // Abort during the RAM phase
    run_dump(1, 0, 33);
    reset = 1'b0;
    tick();
    check_eq("abort_ctrl", {60'd0, cpu_enable, busy, done, out_valid}, 64'b1000);
    reset = 1'b1;
    stray = 0;
    repeat (5) begin
      tick();
      if (done || busy || !cpu_enable) stray++;
    end
    check_eq("abort_no_done", 64'(stray), 64'd0);

    run_dump(1, 0, 0);
    verify_seq("seq_after_abort", 0);

`ifdef DUMP_CHECKSUM_EN
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    run_dump(0, 0, 0);
    verify_seq("seq_csum", 1);
    if (q_words.size() == N_WORDS)
      check_eq("csum_word", 64'(q_words[N_WORDS-1]), {22'd0, 2'b10, 8'h00, 32'h000000A4});
    else
      check_eq("csum_word_present", 64'(q_words.size()), 64'(N_WORDS));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/state_dump_unit.md
Name: state_dump_unit

Overview:
- Debug/verification block that freezes the CPU, then walks the register bank and data RAM and streams every word out over a valid/ready port.
- Replaces end-of-simulation hierarchical dumps with an in-design, synthesizable snapshot path, usable in simulation and on hardware (UART or logic-analyser sink).
- Sits beside `cpu`: drives the CPU `enable` input and owns a dedicated read port on `RegisterBank` and `Ram`.

Parameters:
- DATA_WIDTH, 32, width of register and RAM words.
- REG_ADDR_W, 5, register index width.
- REG_FIRST, 1, first register dumped (x0 skipped by default).
- REG_LAST, 31, last register dumped (inclusive).
- RAM_ADDR_W, 8, RAM word address width.
- RAM_WORDS, 5, number of RAM words dumped from address 0. Must be ≥1 and ≤2^RAM_ADDR_W.
- DRAIN_CYCLES, 4, cycles to hold after deasserting `cpu_enable` so in-flight pipeline writes retire.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a dump.
- cpu_enable  out  1  drives CPU `enable`; 0 while dumping.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the final word handshakes.
- reg_rd_addr  out  REG_ADDR_W  register bank debug read address; data is combinational.
- reg_rd_data  in  DATA_WIDTH  register bank debug read data.
- ram_rd_addr  out  RAM_ADDR_W  RAM debug read address; data is valid 1 cycle after the address.
- ram_rd_data  in  DATA_WIDTH  RAM debug read data.
- out_valid  out  1  stream word valid.
- out_ready  in  1  sink ready.
- out_data  out  DATA_WIDTH  stream word.
- out_tag  out  2  source of the word: 00 = register, 01 = RAM, 10 = checksum.
- out_index  out  8  register index or RAM address of the word, zero-extended.

Behaviour:
- Reset (reset == 0 at a clock edge), whatever the current state:
  - state ← IDLE; cpu_enable = 1; busy = 0; done = 0; out_valid = 0.
  - out_data, out_tag, out_index, reg_rd_addr, ram_rd_addr all = 0.
- IDLE:
  - cpu_enable = 1.
  - start = 1 → DRAIN; cpu_enable = 0 and busy = 1 from the next cycle.
- DRAIN:
  - Counts DRAIN_CYCLES cycles, then → REG.
  - reg_rd_addr is preset to REG_FIRST.
- REG:
  - Registers reg_rd_data into out_data; out_tag = 00; out_index = current index; out_valid = 1; → REG_OUT.
- REG_OUT:
  - Holds all out_* stable while out_valid = 1 and out_ready = 0.
  - On a handshake (valid & ready): if index == REG_LAST → RAM_ADDR with ram_rd_addr = 0; otherwise increment index → REG.
- RAM_ADDR:
  - Address is presented; → RAM_WAIT (1-cycle read latency).
- RAM_WAIT:
  - Captures ram_rd_data into out_data; out_tag = 01; out_index = address; out_valid = 1; → RAM_OUT.
- RAM_OUT:
  - On handshake: if address == RAM_WORDS−1 → FINISH; otherwise increment address → RAM_ADDR.
- FINISH:
  - done = 1 for exactly one cycle; busy = 0 and cpu_enable = 1 on the following cycle; → IDLE.
- Throughput and latency:
  - Registers: one word per 2 cycles; RAM: one word per 3 cycles, with out_ready held high.
  - First out_valid appears DRAIN_CYCLES + 2 cycles after start is sampled.
- out_valid never drops without a handshake except on reset.
- start while busy is ignored; it is not queued.
- Reset mid-dump aborts immediately with no done pulse; the CPU resumes the cycle after reset is released.
- out_index is the low 8 bits of the index or address; higher bits are truncated.
- Stream order is fixed: registers REG_FIRST..REG_LAST ascending, then RAM 0..RAM_WORDS−1 ascending.

Optional Feature:
- Macro: DUMP_CHECKSUM_EN.
- Defined:
  - A running XOR of every emitted out_data is cleared on start.
  - After the last RAM handshake, one extra word is emitted before FINISH: out_data = checksum, out_tag = 10, out_index = 0.
  - The extra word follows the same hold rules.
- Undefined:
  - No checksum logic; FINISH follows the last RAM word directly.
  - out_tag = 10 never appears.

Test Plan:
- Reset held low 3 cycles with start = 1 → cpu_enable = 1, busy = 0, out_valid = 0; no dump starts.
- Registers x1..x31 preloaded with value i·0x11111111, RAM[0..4] = 0xA0..0xA4, out_ready = 1, start pulse →
  - 31 words with tag 00 and index 1..31, then 5 words with tag 01 and index 0..4.
  - done pulses once; cpu_enable is low for the whole dump.
- Same stimulus, out_ready toggled pseudo-randomly → identical word sequence; out_data, out_tag and out_index stay stable through every stall.
- start re-pulsed at word 10 → ignored; the sequence is unchanged and done pulses once.
- reset driven low during the RAM phase → next cycle state = IDLE, cpu_enable = 1, no done pulse; a new start then gives a full dump.
- With DUMP_CHECKSUM_EN: RAM-only values (registers = 0), RAM = 0xA0..0xA4 → final word has tag 10 and data 0x000000A4 (XOR of 0xA0..0xA4).
